// File: rtl/pipe_stage_pkg.sv
// Shared defaults for the pipeline stage register: bundle widths, the control
// value used for bubbles, and the all-ones pattern for the saturating counter.
package pipe_stage_pkg;

    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 16;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = '0;

    // Wide enough for any counter width up to 64 bits; callers slice it down.
    localparam logic [63:0] SAT_ALL_ONES = '1;

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating up-counter of backpressured cycles.
// It holds at all-ones and never wraps.
module pipe_stall_ctr
    import pipe_stage_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT_VAL = SAT_ALL_ONES[CNT_W-1:0];

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != SAT_VAL)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying a control and a data bundle per beat, with
// flush, NOP insert and stall profiling. Define PIPE_STAGE_SKID_EN for a registered skid entry.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int                 CTRL_W   = CTRL_W_DEF,
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 CNT_W    = CNT_W_DEF,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_nop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a beat transfers on a rising edge where valid && ready; the
    // sender keeps valid/ctrl/data stable until then, and ready never waits on valid.

    logic              out_valid_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [DATA_W-1:0] out_data_q;

    logic              accept;
    logic              out_load;
    logic [CTRL_W-1:0] in_ctrl_eff;

    assign accept      = in_valid && in_ready;
    assign out_load    = !out_valid_q || out_ready;
    assign in_ctrl_eff = in_nop ? CTRL_NOP : in_ctrl;

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // ready comes only from a flop, so out_ready never reaches in_ready
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_NOP;
            out_data_q  <= '0;
            skid_valid  <= 1'b0;
            skid_ctrl   <= CTRL_NOP;
            skid_data   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_NOP;
            skid_valid  <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                // skid holds the older beat; no accept is possible while it is full
                out_valid_q <= 1'b1;
                out_ctrl_q  <= skid_ctrl;
                out_data_q  <= skid_data;
                skid_valid  <= 1'b0;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    out_ctrl_q <= in_ctrl_eff;
                    out_data_q <= in_data;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl_eff;
            skid_data  <= in_data;
        end
    end

`else

    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_NOP;
            out_data_q  <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_NOP;
        end else if (out_load) begin
            out_valid_q <= accept;
            if (accept) begin
                out_ctrl_q <= in_ctrl_eff;
                out_data_q <= in_data;
            end
        end
    end

`endif

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;

    pipe_stall_ctr #(
        .CNT_W (CNT_W)
    ) u_stall_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid_q && !out_ready),
        .count (stall_cnt)
    );

endmodule
